// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_arb_pkg
// Description : Shared types and constants for the register-file write-port
//               arbiter. It holds the arbiter state encoding, the grant-source
//               codes and the starvation counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // holding buffer empty
        PEND  = 2'd1,   // buffer full, losing to A
        FORCE = 2'd2    // pipeline stalled, buffer owns the port
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_A    = 2'd1;
    localparam logic [1:0] GNT_B    = 2'd2;

    localparam int STARVE_CNT_W = 4;

endpackage : wb_arb_pkg
`default_nettype wire

// File: rtl/wb_hold_buf.sv
`default_nettype none
// ============================================================================
// Module      : wb_hold_buf
// Description : One-entry holding buffer for out-of-band (B) results.
//               An entry is discarded when a younger write to the same
//               register is granted. This applies both to a stored entry and
//               to an entry arriving in the same cycle.
// Ports       : clk, rst         - clock, asynchronous active-high reset
//               i_load/i_reg/i_data - offered entry (taken only when empty)
//               i_clear          - entry granted, drop it
//               i_kill/i_kill_reg - younger write granted to i_kill_reg
//               o_valid/o_reg/o_data - stored entry
//               o_hit_buf/o_hit_in - kill matched stored / incoming entry
// Revision    : 1.0 - initial release
// ============================================================================
module wb_hold_buf #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [4:0]            i_reg,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_clear,
    input  logic                  i_kill,
    input  logic [4:0]            i_kill_reg,
    output logic                  o_valid,
    output logic [4:0]            o_reg,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_hit_buf,
    output logic                  o_hit_in
);

    logic                  r_valid;
    logic [4:0]            r_reg;
    logic [DATA_WIDTH-1:0] r_data;

    assign o_hit_buf = i_kill & r_valid & (i_kill_reg == r_reg);
    assign o_hit_in  = i_kill & (i_kill_reg == i_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_reg   <= 5'd0;
            r_data  <= '0;
        end else if (i_clear || o_hit_buf) begin
            r_valid <= 1'b0;
        end else if (i_load && !r_valid && !o_hit_in) begin
            r_valid <= 1'b1;
            r_reg   <= i_reg;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_reg   = r_reg;
    assign o_data  = r_data;

endmodule : wb_hold_buf
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the register-file write port between the pipeline
//               writeback stage (A, priority) and a multi-cycle result source
//               (B, via a one-entry holding buffer). A starvation counter
//               forces a one-cycle stall so that a buffered B entry always
//               drains. The write port is registered. Writes to x0 are
//               suppressed.
// Ports       : clock, reset (async, active-high)
//               a_write/a_reg/a_data      - pipeline writeback request
//               b_valid/b_ready/b_reg/b_data - B result handshake
//               stall                     - pipeline freeze (registered)
//               write/write_reg/write_data - register-file write port
//               report                    - per-cycle trace enable
// Macro       : WB_ARB_REPORT_EN - compiles in the cycle counter and trace
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int CORE         = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  a_write,
    input  logic [4:0]            a_reg,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [4:0]            b_reg,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  stall,
    output logic                  write,
    output logic [4:0]            write_reg,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic                  report
);

    localparam logic [STARVE_CNT_W-1:0] c_limit = STARVE_CNT_W'(STARVE_LIMIT);

    arb_state_t               r_state, w_state_nxt;
    logic [STARVE_CNT_W-1:0]  r_starve_cnt, w_starve_nxt;
    logic [1:0]               w_gnt;
    logic                     w_b_xfer;
    logic                     w_clear;
    logic                     w_hit_buf, w_hit_in;
    logic                     w_buf_valid;
    logic [4:0]               w_buf_reg;
    logic [DATA_WIDTH-1:0]    w_buf_data;
    logic [4:0]               w_sel_reg;
    logic [DATA_WIDTH-1:0]    w_sel_data;
    logic                     r_stall, r_write;
    logic [4:0]               r_write_reg;
    logic [DATA_WIDTH-1:0]    r_write_data;

    assign w_b_xfer = b_valid & ~w_buf_valid;
    assign w_clear  = (w_gnt == GNT_B);

    wb_hold_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_hold_buf (
        .clk        (clock),
        .rst        (reset),
        .i_load     (w_b_xfer),
        .i_reg      (b_reg),
        .i_data     (b_data),
        .i_clear    (w_clear),
        .i_kill     (w_gnt == GNT_A),
        .i_kill_reg (a_reg),
        .o_valid    (w_buf_valid),
        .o_reg      (w_buf_reg),
        .o_data     (w_buf_data),
        .o_hit_buf  (w_hit_buf),
        .o_hit_in   (w_hit_in)
    );

    // Grant depends only on state and a_write. It is kept apart from the
    // next-state logic, which consumes the buffer's kill matches.
    always_comb begin
        w_gnt = GNT_NONE;
        case (r_state)
            IDLE:    w_gnt = a_write ? GNT_A : GNT_NONE;
            PEND:    w_gnt = a_write ? GNT_A : GNT_B;
            FORCE:   w_gnt = GNT_B;
            default: w_gnt = GNT_NONE;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve_cnt;
        case (r_state)
            IDLE: begin
                w_starve_nxt = '0;
                // An incoming entry killed by a same-cycle A grant is dropped.
                if (w_b_xfer && !w_hit_in) begin
                    w_state_nxt = PEND;
                end
            end
            PEND: begin
                if (w_gnt == GNT_B || w_hit_buf) begin
                    w_state_nxt  = IDLE;
                    w_starve_nxt = '0;
                end else begin
                    w_starve_nxt = r_starve_cnt + 1'b1;
                    if (w_starve_nxt == c_limit) begin
                        w_state_nxt = FORCE;
                    end
                end
            end
            FORCE: begin
                w_state_nxt  = IDLE;
                w_starve_nxt = '0;
            end
            default: begin
                w_state_nxt  = IDLE;
                w_starve_nxt = '0;
            end
        endcase
    end

    always_comb begin
        w_sel_reg  = a_reg;
        w_sel_data = a_data;
        if (w_gnt == GNT_B) begin
            w_sel_reg  = w_buf_reg;
            w_sel_data = w_buf_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_stall      <= 1'b0;
            r_write      <= 1'b0;
            r_write_reg  <= 5'd0;
            r_write_data <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_stall      <= (w_state_nxt == FORCE);
            // An x0 grant still consumes its slot but never writes.
            r_write      <= (w_gnt != GNT_NONE) && (w_sel_reg != 5'd0);
            if (w_gnt != GNT_NONE) begin
                r_write_reg  <= w_sel_reg;
                r_write_data <= w_sel_data;
            end
        end
    end

    assign b_ready    = ~w_buf_valid;
    assign stall      = r_stall;
    assign write      = r_write;
    assign write_reg  = r_write_reg;
    assign write_data = r_write_data;

`ifdef WB_ARB_REPORT_EN
    logic [31:0] r_cycle;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cycle <= 32'd0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    always @(posedge clock) begin
        if (report) begin
            $display("wb_arb core %0d cycle %0d state %0d buf_valid %0b buf_reg %0d starve %0d stall %0b write %0b reg %0d data %h",
                     CORE, r_cycle, r_state, w_buf_valid, w_buf_reg, r_starve_cnt,
                     r_stall, r_write, r_write_reg, r_write_data);
        end
    end
`else
    logic w_unused_report;
    assign w_unused_report = report | (CORE < 0);
`endif

endmodule : wb_port_arbiter
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Directed self-checking bench for wb_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        a_write = 1'b0;
    logic [4:0]  a_reg = 5'd0;
    logic [31:0] a_data = 32'd0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [4:0]  b_reg = 5'd0;
    logic [31:0] b_data = 32'd0;
    logic        stall;
    logic        write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        report = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    wb_port_arbiter #(
        .DATA_WIDTH   (32),
        .CORE         (0),
        .STARVE_LIMIT (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .a_write    (a_write),
        .a_reg      (a_reg),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_reg      (b_reg),
        .b_data     (b_data),
        .stall      (stall),
        .write      (write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .report     (report)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        a_write = 1'b0;
        b_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    logic [4:0] exp_reg [2:10];
    int         a_idx;
    logic       ps;

    initial begin
        exp_reg[2] = 5'd1; exp_reg[3] = 5'd2; exp_reg[4]  = 5'd3;
        exp_reg[5] = 5'd4; exp_reg[6] = 5'd9; exp_reg[7]  = 5'd5;
        exp_reg[8] = 5'd6; exp_reg[9] = 5'd7; exp_reg[10] = 5'd8;

        // Reset state
        step(); step();
        reset = 1'b0;
        check("rst_write",   {31'd0, write}, 32'd0);
        check("rst_reg",     {27'd0, write_reg}, 32'd0);
        check("rst_data",    write_data, 32'd0);
        check("rst_stall",   {31'd0, stall}, 32'd0);
        check("rst_b_ready", {31'd0, b_ready}, 32'd1);

        // A alone, back-to-back, plus an x0 write
        a_write = 1'b1; a_reg = 5'd10; a_data = 32'h0000_0A0A;
        step();
        a_reg = 5'd11; a_data = 32'h0000_0B0B;
        check("a0_write", {31'd0, write}, 32'd1);
        check("a0_reg",   {27'd0, write_reg}, 32'd10);
        check("a0_data",  write_data, 32'h0000_0A0A);
        step();
        a_reg = 5'd0; a_data = 32'hDEAD_0000;
        check("a1_reg",   {27'd0, write_reg}, 32'd11);
        check("a1_data",  write_data, 32'h0000_0B0B);
        step();
        a_write = 1'b0;
        check("a_x0_write", {31'd0, write}, 32'd0);
        idle(2);

        // B alone: transfer r7 in cycle 0, write in cycle 2
        b_valid = 1'b1; b_reg = 5'd7; b_data = 32'h0000_1234;
        check("b_c0_ready", {31'd0, b_ready}, 32'd1);
        step();
        b_valid = 1'b0;
        check("b_c1_ready", {31'd0, b_ready}, 32'd0);
        check("b_c1_write", {31'd0, write}, 32'd0);
        step();
        check("b_c2_write", {31'd0, write}, 32'd1);
        check("b_c2_reg",   {27'd0, write_reg}, 32'd7);
        check("b_c2_data",  write_data, 32'h0000_1234);
        check("b_c2_ready", {31'd0, b_ready}, 32'd1);
        step();
        check("b_c3_write", {31'd0, write}, 32'd0);
        idle(2);

        // Starvation: B r9 buffered, A streams r1..r8 and honours stall
        b_valid = 1'b1; b_reg = 5'd9; b_data = 32'h0000_B009;
        step();
        b_valid = 1'b0;
        a_idx = 1;
        a_write = 1'b1; a_reg = 5'(a_idx); a_data = 32'h0000_A000 + a_idx;
        ps = stall;
        for (int c = 2; c <= 11; c++) begin
            step();
            check($sformatf("stv_stall_c%0d", c), {31'd0, stall}, {31'd0, c == 5});
            if (c <= 10) begin
                check($sformatf("stv_write_c%0d", c), {31'd0, write}, 32'd1);
                check($sformatf("stv_reg_c%0d", c), {27'd0, write_reg}, {27'd0, exp_reg[c]});
                check($sformatf("stv_data_c%0d", c), write_data,
                      (exp_reg[c] == 5'd9) ? 32'h0000_B009 : 32'h0000_A000 + {27'd0, exp_reg[c]});
            end else begin
                check("stv_write_end", {31'd0, write}, 32'd0);
            end
            if (!ps) a_idx++;
            if (a_idx <= 8) begin
                a_write = 1'b1; a_reg = 5'(a_idx); a_data = 32'h0000_A000 + a_idx;
            end else begin
                a_write = 1'b0;
            end
            ps = stall;
        end
        idle(2);

        // Kill: buffered r3 = AAAA overtaken by A r3 = 5555
        b_valid = 1'b1; b_reg = 5'd3; b_data = 32'h0000_AAAA;
        step();
        b_valid = 1'b0;
        a_write = 1'b1; a_reg = 5'd3; a_data = 32'h0000_5555;
        check("kill_c1_ready", {31'd0, b_ready}, 32'd0);
        step();
        a_write = 1'b0;
        check("kill_c2_write", {31'd0, write}, 32'd1);
        check("kill_c2_reg",   {27'd0, write_reg}, 32'd3);
        check("kill_c2_data",  write_data, 32'h0000_5555);
        check("kill_c2_ready", {31'd0, b_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("kill_no_b_write", {31'd0, write}, 32'd0);
        end

        // Same-cycle B transfer and A grant to r4: B is accepted and dropped
        a_write = 1'b1; a_reg = 5'd4; a_data = 32'h0000_4444;
        b_valid = 1'b1; b_reg = 5'd4; b_data = 32'h0000_BBBB;
        step();
        a_write = 1'b0; b_valid = 1'b0;
        check("same_write", {31'd0, write}, 32'd1);
        check("same_data",  write_data, 32'h0000_4444);
        check("same_ready", {31'd0, b_ready}, 32'd1);
        step();
        check("same_no_b", {31'd0, write}, 32'd0);
        idle(2);

        // B to x0 with A idle
        b_valid = 1'b1; b_reg = 5'd0; b_data = 32'h0000_0F0F;
        step();
        b_valid = 1'b0;
        check("bx0_c1_ready", {31'd0, b_ready}, 32'd0);
        step();
        check("bx0_c2_write", {31'd0, write}, 32'd0);
        check("bx0_c2_ready", {31'd0, b_ready}, 32'd1);
        idle(2);

        // Reset while B r5 is pending behind A traffic
        b_valid = 1'b1; b_reg = 5'd5; b_data = 32'h0000_5005;
        step();
        b_valid = 1'b0;
        a_write = 1'b1; a_reg = 5'd1; a_data = 32'h0000_0001;
        check("prst_pend_ready", {31'd0, b_ready}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("prst_write", {31'd0, write}, 32'd0);
        check("prst_ready", {31'd0, b_ready}, 32'd1);
        step();
        reset = 1'b0;
        a_write = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("prst_no_r5", {31'd0, write && (write_reg == 5'd5)}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_wb_port_arbiter
`default_nettype wire

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline writeback stage (requester A) and an out-of-band multi-cycle result source such as a divider or CSR/refill unit (requester B). It sits between the writeback unit and the register file. A has priority. B results are parked in a one-entry holding buffer, and a starvation counter forces a one-cycle pipeline stall so B always drains. The write port is registered, and writes to x0 are suppressed.

## Interface
- `DATA_WIDTH`, 32, register data width
- `CORE`, 0, core index used in report output
- `STARVE_LIMIT`, 4, consecutive cycles a buffered B entry may lose to A before a forced grant (legal range 1–15)

- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `a_write`  in  1  pipeline writeback wants to write this cycle
- `a_reg`  in  5  pipeline destination register
- `a_data`  in  DATA_WIDTH  pipeline write data
- `b_valid`  in  1  B result offered
- `b_ready`  out  1  holding buffer empty; a B transfer occurs when `b_valid & b_ready`
- `b_reg`  in  5  B destination register
- `b_data`  in  DATA_WIDTH  B result data
- `stall`  out  1  freezes the pipeline; while high, A must hold `a_*` stable and it is not granted
- `write`  out  1  register-file write enable
- `write_reg`  out  5  register-file write address
- `write_data`  out  DATA_WIDTH  register-file write data
- `report`  in  1  enables per-cycle report (see Configuration)

## Operation
- Holding buffer: `buf_valid`, `buf_reg`, `buf_data`. `b_ready = ~buf_valid`, so B sees a combinational, registered-state ready.
- A B transfer loads the buffer. The buffer may be granted no earlier than the cycle after the load.
- States:
  - IDLE: buffer empty.
  - PEND: buffer full, waiting.
  - FORCE: stall asserted, buffer granted.
- Per-cycle grant:
  - FORCE: grant the buffer, ignore A, clear the buffer, go to IDLE.
  - PEND with `a_write = 0`: grant the buffer, clear it, go to IDLE.
  - PEND with `a_write = 1`: grant A, increment `starve_cnt`. When `starve_cnt` reaches `STARVE_LIMIT`, go to FORCE.
  - IDLE: grant A if `a_write`.
- Kill rule: if A is granted with `a_reg == buf_reg` while the buffer is valid, the buffer entry is discarded, because A is younger. The buffer clears, `starve_cnt` clears, and the state goes to IDLE.
- A same-cycle B transfer and A grant to the same register also discards the incoming B entry. `b_ready` is still 1 and the transfer is accepted and dropped.
- x0: any grant whose register is 0 produces `write = 0` for that slot. The grant still consumes the buffer or the A slot.
- `starve_cnt` is 4 bits and clears whenever the buffer empties.

## Timing
- Reset values: `write = 0`, `write_reg = 0`, `write_data = 0`, `stall = 0`, `b_ready = 1`, state IDLE, buffer empty, `starve_cnt = 0`.
- Reset mid-operation discards any buffered B entry.
- Latency: granted request in cycle N gives `write`, `write_reg` and `write_data` registered and valid in cycle N+1, for one cycle.
- `stall` is a registered output. It is high exactly in FORCE cycles, one cycle per forced grant.
- Back-to-back cycles:
  - A can write every cycle.
  - B can write at most every other cycle, because the buffer loads, then drains.
  - A new B transfer is accepted in the cycle after the buffer clears.
- With B pending and A writing continuously, the B write appears at most `STARVE_LIMIT + 2` cycles after the B transfer.

## Configuration
- `WB_ARB_REPORT_EN` defined:
  - A 32-bit cycle counter is compiled in, reset to 0.
  - When `report` is high, each rising edge `$display`s the core, cycle, state, `buf_valid`, `buf_reg`, `starve_cnt`, `stall`, `write`, `write_reg` and `write_data`.
- Undefined: no counter and no display logic. `report` is ignored, and functional behaviour is identical.

## Structure
- Shared package `wb_arb_pkg`:
  - state enum `{IDLE, PEND, FORCE}`, 2 bits
  - grant-source constants `GNT_NONE`, `GNT_A`, `GNT_B`
  - `STARVE_CNT_W = 4`
- One natural sub-module: `wb_hold_buf`, the one-entry valid/ready buffer. It has load, clear, kill-on-register-match, and `buf_*` outputs.
- Grant logic, FSM and output registers live in the top.

## Test plan
- Reset during PEND with a buffered `b_reg = 5` → after reset `write = 0`, `b_ready = 1`, and no later write to r5.
- A idle, B transfers r7 = 0x1234 in cycle 0 → buffer granted in cycle 1, `write = 1`, `write_reg = 7`, `write_data = 0x1234` in cycle 2, `b_ready` back to 1 in cycle 2.
- B transfers r9, then A writes r1–r8 every cycle with `STARVE_LIMIT = 4` → four A writes, then `stall = 1` for one cycle with the r9 write, then the held A resumes with no A write lost.
- B buffered r3 = 0xAAAA, then A writes r3 = 0x5555 → only 0x5555 is written to r3, the buffer clears and `b_ready` rises.
- B transfers `b_reg = 0` while A is idle → `write` stays 0, and `b_ready` returns to 1 two cycles later.
- Random A/B traffic for 10k cycles against a reference model → every non-killed, non-x0 request is written exactly once, in the order defined in Operation.
